// File: rtl/fc_ctrl_pkg.sv
// fc_ctrl_pkg: shared state encoding and width helper for the
// fully-connected layer sequencer.
package fc_ctrl_pkg;

    typedef enum logic [2:0] {
        s_ctrl_idle      = 3'd0,
        s_ctrl_issue     = 3'd1,
        s_ctrl_wait      = 3'd2,
        s_ctrl_drain_req = 3'd3,
        s_ctrl_drain     = 3'd4
    } t_ctrl_state;

    // Pass-index width; a single binary pass still needs one bit.
    function automatic int calc_bit_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_ctrl_perf.sv
// fc_ctrl_perf: saturating busy/stall cycle counters, built only
// when FC_CTRL_PERF_EN is defined.
module fc_ctrl_perf
    import fc_ctrl_pkg::*;
#(
    parameter int PERF_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_busy,
    input  logic                  i_stall,
    output logic [PERF_WIDTH-1:0] o_busy_cycles,
    output logic [PERF_WIDTH-1:0] o_stall_cycles
);

    logic [PERF_WIDTH-1:0] busy_q, busy_d;
    logic [PERF_WIDTH-1:0] stall_q, stall_d;

    always_comb begin
        busy_d  = busy_q;
        stall_d = stall_q;
        if (i_busy && !(&busy_q)) begin
            busy_d = busy_q + PERF_WIDTH'(1);
        end
        if (i_stall && !(&stall_q)) begin
            stall_d = stall_q + PERF_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= '0;
            stall_q <= '0;
        end else begin
            busy_q  <= busy_d;
            stall_q <= stall_d;
        end
    end

    assign o_busy_cycles  = busy_q;
    assign o_stall_cycles = stall_q;

endmodule

// File: rtl/fc_layer_ctrl.sv
// fc_layer_ctrl: bit-serial crossbar pass sequencer for one FC layer.
// Optional perf counters are enabled with FC_CTRL_PERF_EN.
module fc_layer_ctrl
    import fc_ctrl_pkg::*;
#(
    parameter int DATA_SIZE  = 8,
    parameter int PERF_WIDTH = 32,
    parameter int BIT_W      = calc_bit_w(DATA_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    output logic                  o_ready,
    output logic                  o_cim_start,
    output logic [BIT_W-1:0]      o_cim_bit,
    input  logic                  i_cim_ready,
    output logic                  o_ibuf_release,
    output logic                  o_func_start,
    input  logic                  i_func_ready,
    input  logic                  i_next_ready,
    output logic                  o_done,
    output logic [PERF_WIDTH-1:0] o_busy_cycles,
    output logic [PERF_WIDTH-1:0] o_stall_cycles
);

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_SIZE - 1);

    t_ctrl_state      state_q, state_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             guard_q, guard_d;
    logic             seen_busy_q, seen_busy_d;
    logic             drain_go;
    logic             stall;

    assign drain_go = i_func_ready & i_next_ready & i_cim_ready;

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        guard_d        = 1'b0;
        seen_busy_d    = seen_busy_q;
        o_cim_start    = 1'b0;
        o_ibuf_release = 1'b0;
        o_func_start   = 1'b0;
        o_done         = 1'b0;
        stall          = 1'b0;
        unique case (state_q)
            s_ctrl_idle: begin
                if (i_start) begin
                    state_d   = s_ctrl_issue;
                    bit_cnt_d = '0;
                end
            end
            s_ctrl_issue: begin
                o_cim_start = i_cim_ready;
                if (i_cim_ready) begin
                    state_d = s_ctrl_wait;
                    guard_d = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            // First wait cycle is a guard: CIM ready may still be stale.
            s_ctrl_wait: begin
                if (!guard_q && i_cim_ready) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        o_ibuf_release = 1'b1;
                        state_d        = s_ctrl_drain_req;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        state_d   = s_ctrl_issue;
                    end
                end
            end
            s_ctrl_drain_req: begin
                o_func_start = drain_go;
                if (drain_go) begin
                    state_d     = s_ctrl_drain;
                    seen_busy_d = 1'b0;
                end else begin
                    stall = 1'b1;
                end
            end
            // Done only after the func unit has visibly gone busy and back.
            s_ctrl_drain: begin
                if (!i_func_ready) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q) begin
                    o_done  = 1'b1;
                    state_d = s_ctrl_idle;
                end
            end
            default: begin
                state_d = s_ctrl_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= s_ctrl_idle;
            bit_cnt_q   <= '0;
            guard_q     <= 1'b0;
            seen_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            guard_q     <= guard_d;
            seen_busy_q <= seen_busy_d;
        end
    end

    assign o_ready   = (state_q == s_ctrl_idle);
    assign o_cim_bit = o_ready ? '0 : bit_cnt_q;

`ifdef FC_CTRL_PERF_EN
    fc_ctrl_perf #(
        .PERF_WIDTH(PERF_WIDTH)
    ) u_perf (
        .clk           (clk),
        .rst           (rst),
        .i_busy        (state_q != s_ctrl_idle),
        .i_stall       (stall),
        .o_busy_cycles (o_busy_cycles),
        .o_stall_cycles(o_stall_cycles)
    );
`else
    logic unused_stall;
    assign unused_stall   = stall;
    assign o_busy_cycles  = '0;
    assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// tb_fc_layer_ctrl: scoreboard bench for fc_layer_ctrl with CIM and
// func unit models; two instances cover DATA_SIZE=4 and DATA_SIZE=1.
module tb_fc_layer_ctrl;

`ifdef FC_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam int K_START = 0;
    localparam int K_REL   = 1;
    localparam int K_FST   = 2;
    localparam int K_DONE  = 3;

    typedef struct {
        int unit;
        int kind;
        int bits;
        int cyc;
    } ev_t;

    ev_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DATA_SIZE=4 instance
    logic        i_start, o_ready, o_cim_start, o_ibuf_release;
    logic        o_func_start, o_done, i_cim_ready, i_func_ready;
    logic        i_next_ready;
    logic [1:0]  o_cim_bit;
    logic [31:0] o_busy_cycles, o_stall_cycles;

    // DATA_SIZE=1 instance
    logic        s1_start, r1_ready, r1_cim_start, r1_rel;
    logic        r1_fst, r1_done, f1_ready;
    logic [0:0]  r1_cim_bit;
    logic [31:0] r1_busy, r1_stall;
    logic        one = 1'b1;

    fc_layer_ctrl #(.DATA_SIZE(4), .PERF_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .o_ready       (o_ready),
        .o_cim_start   (o_cim_start),
        .o_cim_bit     (o_cim_bit),
        .i_cim_ready   (i_cim_ready),
        .o_ibuf_release(o_ibuf_release),
        .o_func_start  (o_func_start),
        .i_func_ready  (i_func_ready),
        .i_next_ready  (i_next_ready),
        .o_done        (o_done),
        .o_busy_cycles (o_busy_cycles),
        .o_stall_cycles(o_stall_cycles)
    );

    fc_layer_ctrl #(.DATA_SIZE(1), .PERF_WIDTH(32)) dut1 (
        .clk           (clk),
        .rst           (rst),
        .i_start       (s1_start),
        .o_ready       (r1_ready),
        .o_cim_start   (r1_cim_start),
        .o_cim_bit     (r1_cim_bit),
        .i_cim_ready   (one),
        .o_ibuf_release(r1_rel),
        .o_func_start  (r1_fst),
        .i_func_ready  (f1_ready),
        .i_next_ready  (one),
        .o_done        (r1_done),
        .o_busy_cycles (r1_busy),
        .o_stall_cycles(r1_stall)
    );

    // CIM model: ready drops for cim_drop cycles after each start
    int   cim_cnt;
    int   cim_drop;
    logic cim_hold;
    always @(posedge clk or posedge rst)
        if (rst) cim_cnt <= 0;
        else if (o_cim_start) cim_cnt <= cim_drop;
        else if (cim_cnt > 0) cim_cnt <= cim_cnt - 1;
    assign i_cim_ready = (cim_cnt == 0) && !cim_hold;

    // Func models: busy 4 cycles after each func start
    int f_cnt, f1_cnt;
    always @(posedge clk or posedge rst)
        if (rst) f_cnt <= 0;
        else if (o_func_start) f_cnt <= 4;
        else if (f_cnt > 0) f_cnt <= f_cnt - 1;
    assign i_func_ready = (f_cnt == 0);
    always @(posedge clk or posedge rst)
        if (rst) f1_cnt <= 0;
        else if (r1_fst) f1_cnt <= 4;
        else if (f1_cnt > 0) f1_cnt <= f1_cnt - 1;
    assign f1_ready = (f1_cnt == 0);

    function automatic void push(input int u, input int k,
                                 input int b, input int c);
        ev_t e;
        e.unit = u; e.kind = k; e.bits = b; e.cyc = c;
        sb.push_back(e);
    endfunction

    task automatic observe(input int u, input int k, input int b);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: unit=%0d kind=%0d bit=%0d cyc=%0d, required none",
                     u, k, b, cyc);
        end else begin
            e = sb.pop_front();
            if (e.unit != u || e.kind != k || e.bits != b || e.cyc != cyc) begin
                errors++;
                $display("FAIL event: got unit=%0d kind=%0d bit=%0d cyc=%0d, required unit=%0d kind=%0d bit=%0d cyc=%0d",
                         u, k, b, cyc, e.unit, e.kind, e.bits, e.cyc);
            end
        end
    endtask

    // Monitor: every pulse seen must match the head of the scoreboard
    always @(negedge clk) begin
        if (o_cim_start)    observe(0, K_START, int'(o_cim_bit));
        if (o_ibuf_release) observe(0, K_REL, 0);
        if (o_func_start)   observe(0, K_FST, 0);
        if (o_done)         observe(0, K_DONE, 0);
        if (r1_cim_start)   observe(1, K_START, int'(r1_cim_bit));
        if (r1_rel)         observe(1, K_REL, 0);
        if (r1_fst)         observe(1, K_FST, 0);
        if (r1_done)        observe(1, K_DONE, 0);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    // Layer on dut with pass spacing p, first start at t+1+s0
    task automatic push_layer(input int t, input int p);
        for (int i = 0; i < 4; i++) push(0, K_START, i, t + 1 + i * p);
    endtask

    int t;

    initial begin
        rst = 1'b1;
        i_start = 1'b0; s1_start = 1'b0;
        i_next_ready = 1'b1; cim_hold = 1'b0; cim_drop = 2;
        repeat (3) tick();
        check("rst_ready", int'(o_ready), 1);
        check("rst_ready1", int'(r1_ready), 1);
        check("rst_bit", int'(o_cim_bit), 0);
        check("rst_busy", int'(o_busy_cycles), 0);
        check("rst_stall", int'(o_stall_cycles), 0);
        rst = 1'b0;
        tick();

        // Nominal: CIM busy 2 cycles after each start
        t = cyc;
        i_start = 1'b1;
        push_layer(t, 4);
        push(0, K_REL, 0, t + 16);
        push(0, K_FST, 0, t + 17);
        push(0, K_DONE, 0, t + 22);
        tick();
        i_start = 1'b0;
        run_to(t + 23);
        check("nom_idle_bit", int'(o_cim_bit), 0);
        check("nom_busy", int'(o_busy_cycles), PERF ? 22 : 0);
        check("nom_stall", int'(o_stall_cycles), 0);

        // CIM stall 5 cycles in issue, then downstream stall 7 cycles
        cim_drop = 0;
        t = cyc;
        i_start = 1'b1; cim_hold = 1'b1; i_next_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(0, K_START, i, t + 6 + 3 * i);
        push(0, K_REL, 0, t + 17);
        push(0, K_FST, 0, t + 25);
        push(0, K_DONE, 0, t + 30);
        tick();
        i_start = 1'b0;
        run_to(t + 6);
        cim_hold = 1'b0;
        run_to(t + 16);
        check("stl_bit3", int'(o_cim_bit), 3);
        check("stl_notready", int'(o_ready), 0);
        run_to(t + 25);
        i_next_ready = 1'b1;
        run_to(t + 31);
        check("stl_busy", int'(o_busy_cycles), PERF ? 52 : 0);
        check("stl_stall", int'(o_stall_cycles), PERF ? 12 : 0);

        // Single binary pass on the DATA_SIZE=1 instance
        t = cyc;
        s1_start = 1'b1;
        push(1, K_START, 0, t + 1);
        push(1, K_REL, 0, t + 3);
        push(1, K_FST, 0, t + 4);
        push(1, K_DONE, 0, t + 9);
        tick();
        s1_start = 1'b0;
        run_to(t + 10);

        // Reset during the wait of pass 2
        cim_drop = 2;
        t = cyc;
        i_start = 1'b1;
        push(0, K_START, 0, t + 1);
        push(0, K_START, 1, t + 5);
        tick();
        i_start = 1'b0;
        run_to(t + 7);
        rst = 1'b1;
        #1;
        check("mrst_ready", int'(o_ready), 1);
        check("mrst_bit", int'(o_cim_bit), 0);
        check("mrst_busy", int'(o_busy_cycles), 0);
        check("mrst_stall", int'(o_stall_cycles), 0);
        check("mrst_pending", sb.size(), 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        tick();
        t = cyc;
        i_start = 1'b1;
        push_layer(t, 4);
        push(0, K_REL, 0, t + 16);
        push(0, K_FST, 0, t + 17);
        push(0, K_DONE, 0, t + 22);
        tick();
        i_start = 1'b0;
        run_to(t + 23);
        check("rep_busy", int'(o_busy_cycles), PERF ? 22 : 0);

        // i_start held high: back-to-back layers at minimum pass period
        cim_drop = 0;
        t = cyc;
        i_start = 1'b1;
        push_layer(t, 3);
        push(0, K_REL, 0, t + 12);
        push(0, K_FST, 0, t + 13);
        push(0, K_DONE, 0, t + 18);
        push_layer(t + 19, 3);
        push(0, K_REL, 0, t + 31);
        push(0, K_FST, 0, t + 32);
        push(0, K_DONE, 0, t + 37);
        run_to(t + 18);
        check("b2b_ready_done", int'(o_ready), 0);
        run_to(t + 19);
        check("b2b_ready_next", int'(o_ready), 1);
        run_to(t + 20);
        i_start = 1'b0;
        run_to(t + 38);
        check("b2b_busy", int'(o_busy_cycles), PERF ? 58 : 0);
        check("b2b_stall", int'(o_stall_cycles), 0);

        while (sb.size() > 0) begin
            ev_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event: got none, required unit=%0d kind=%0d bit=%0d cyc=%0d",
                     e.unit, e.kind, e.bits, e.cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fc_layer_ctrl.md
# fc_layer_ctrl

Sequencer for one fully-connected layer. Accepts a loaded input-buffer vector, issues one bit-serial crossbar pass per input bit to the CIM tile array, then triggers the func unit to drain the output buffer into the next layer. Sits between the upstream input buffer, the CIM tile array and the downstream func unit. It owns the only handshake path between these three.

## Interface
- DATA_SIZE, 8, input bit width; number of crossbar passes per vector (1 → single binary pass)
- PERF_WIDTH, 32, width of performance counters
- BIT_W, (DATA_SIZE>1)?$clog2(DATA_SIZE):1, derived, width of pass index

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  input buffer holds a complete vector
- o_ready  out  1  controller idle, i_start will be accepted
- o_cim_start  out  1  one-cycle pulse, launch crossbar pass
- o_cim_bit  out  BIT_W  input bit slice for current pass, LSB first
- i_cim_ready  in  1  CIM array idle / previous pass complete
- o_ibuf_release  out  1  one-cycle pulse, input buffer may be overwritten
- o_func_start  out  1  one-cycle pulse to func unit
- i_func_ready  in  1  func unit idle
- i_next_ready  in  1  downstream input buffer can accept data
- o_done  out  1  one-cycle pulse, layer result fully drained
- o_busy_cycles  out  PERF_WIDTH  cycles spent outside idle
- o_stall_cycles  out  PERF_WIDTH  cycles blocked on a handshake

## Operation
- States: s_ctrl_idle, s_ctrl_issue, s_ctrl_wait, s_ctrl_drain_req, s_ctrl_drain.
- idle: o_ready=1. i_start=1 → issue, bit_cnt←0. The controller ignores i_start in all other states.
- issue: o_cim_start = i_cim_ready (Mealy). When i_cim_ready=1, the next state is wait. Otherwise it stays in issue and the cycle counts as a stall.
- wait: the first cycle in wait is a guard cycle, and i_cim_ready is ignored during it. On a later cycle with i_cim_ready=1:
  - if bit_cnt==DATA_SIZE-1: pulse o_ibuf_release this cycle, go to drain_req.
  - else: bit_cnt←bit_cnt+1, go to issue.
- o_cim_bit = bit_cnt in every state; it is 0 in idle.
- drain_req: o_func_start = i_func_ready & i_next_ready & i_cim_ready. When it is 1, go to drain and clear seen_busy. Otherwise the cycle counts as a stall.
- drain: seen_busy←1 on i_func_ready=0. On i_func_ready=1 with seen_busy=1: pulse o_done, go to idle. The earliest i_start is accepted the cycle after o_done.
- bit_cnt never wraps. It resets only on i_start acceptance or on rst.

## Timing
- While rst is high and after reset: state=idle, bit_cnt=0, seen_busy=0, o_ready=1, all pulses=0, counters=0.
- The pulses are combinational from the state register and the inputs, and last exactly one cycle.
- From i_start sampled at cycle t, the first o_cim_start occurs at t+1 if i_cim_ready=1.
- Minimum pass period is 3 cycles: issue, guard, ready.
- Minimum layer latency, from i_start to o_done, is 3·DATA_SIZE+3 cycles plus the func busy time.
- Reset asserted mid-operation: return to idle immediately (asynchronously), abort any pass, and emit no o_done or o_ibuf_release.
- If i_start and rst are asserted together, rst wins.

## Configuration
- FC_CTRL_PERF_EN defined:
  - o_busy_cycles increments every cycle with state≠idle.
  - o_stall_cycles increments every cycle in issue with i_cim_ready=0, and every cycle in drain_req with the start condition false.
  - Both counters saturate at all-ones and clear only on rst.
- FC_CTRL_PERF_EN undefined: both ports are present and tied to 0, and no counter logic is synthesized.

## Structure
- Package fc_ctrl_pkg holds:
  - the t_ctrl_state enum;
  - a function that computes BIT_W from DATA_SIZE.
- Sub-module fc_ctrl_perf contains the two saturating counters. It is instantiated only under FC_CTRL_PERF_EN.

## Test plan
- Nominal pass sequencing. Setup: DATA_SIZE=4; CIM model drops ready for 2 cycles after each start; func model busy 4 cycles; i_next_ready=1. Required response:
  - exactly 4 o_cim_start pulses with o_cim_bit=0,1,2,3;
  - one o_ibuf_release, in the same cycle as the 4th pass completes;
  - one o_func_start;
  - o_done once.
- CIM stall. Setup: hold i_cim_ready=0 for 5 cycles in issue. Required response: no o_cim_start during the stall; o_stall_cycles +5 (PERF_EN).
- Downstream backpressure. Setup: i_next_ready=0 for 7 cycles in drain_req. Required response: o_func_start is withheld until i_next_ready rises; o_stall_cycles +7.
- Single binary pass. Setup: DATA_SIZE=1. Required response: one o_cim_start with o_cim_bit=0, followed by o_ibuf_release and then o_done.
- Mid-operation reset. Setup: rst pulsed during the pass 2 wait. Required response: o_ready=1 in the same cycle; counters=0; no o_done. A new i_start replays from bit 0.
- Start outside idle. Setup: i_start held high continuously. Required response: layers run back-to-back, and each new layer is accepted only in the cycle after o_done.
